// File: rtl/logic_unit_pipe.sv
// Pipelined bitwise logic lane for the EX stage: eight ops, zero flag, STAGES register stages,
// valid/ready on both sides and a synchronous flush for branch-mispredict recovery.
module logic_unit_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] f,
    output logic             zero
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both high.
    // in_ready is low during flush; the output side is unaffected by flush.

    logic [WIDTH-1:0]  res;
    logic [STAGES-1:0] vld_q;
    logic [STAGES-1:0] vld_d;
    logic [STAGES-1:0] rdy;
    logic [STAGES-1:0] load;
    logic [WIDTH-1:0]  f_q [STAGES];
    logic [STAGES-1:0] z_q;

    always_comb begin
        res = '0;
        case (op)
            3'b000:  res = a & b;
            3'b001:  res = a | b;
            3'b010:  res = a ^ b;
            3'b011:  res = ~(a | b);
            3'b100:  res = ~(a & b);
            3'b101:  res = ~(a ^ b);
            3'b110:  res = a & ~b;
            default: res = a;
        endcase
    end

    assign in_ready = !flush && rdy[0];

    genvar k;
    generate
        for (k = 0; k < STAGES; k++) begin : g_stage
            // A stage can take new data unless it and every stage after it is full
            // while the consumer stalls; this keeps the ready chain bubble-free.
            assign rdy[k] = out_ready || !(&vld_q[STAGES-1:k]);
            if (k == 0) begin : g_first
                assign load[k] = rdy[k] && in_valid && !flush;
            end else begin : g_next
                assign load[k] = rdy[k] && vld_q[k-1];
            end
            assign vld_d[k] = flush ? 1'b0 : (rdy[k] ? load[k] : vld_q[k]);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            z_q   <= '0;
            for (int i = 0; i < STAGES; i++) begin
                f_q[i] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            if (load[0]) begin
                f_q[0] <= res;
                z_q[0] <= ~|res;
            end
            for (int i = 1; i < STAGES; i++) begin
                if (load[i]) begin
                    f_q[i] <= f_q[i-1];
                    z_q[i] <= z_q[i-1];
                end
            end
        end
    end

    assign out_valid = vld_q[STAGES-1];
    assign f         = f_q[STAGES-1];
    assign zero      = z_q[STAGES-1];

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Bench for logic_unit_pipe: default build (32b, 2 stages) plus 8b/1-stage and 64b/4-stage builds
// sharing the op sweep; expected results flow through per-instance queues.
module tb_logic_unit_pipe;

    localparam int S32 = 2;
    localparam int S8  = 1;
    localparam int S64 = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass = 0;

    logic [2:0] op = '0;

    // 32-bit main instance
    logic        flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1, lat_on = 1'b0, rnd_bp = 1'b0;
    logic        in_ready, out_valid, zero;
    logic [31:0] a32 = '0, b32 = '0, f, exp32 = '0;
    logic [31:0] exp_q[$];
    int          t_q[$];

    // 8-bit, 1-stage instance
    logic        v8 = 1'b0, fl8 = 1'b0, or8 = 1'b1, ir8, ov8, z8;
    logic [7:0]  a8 = '0, b8 = '0, f8, exp8 = '0;
    logic [7:0]  exp8_q[$];
    int          t8_q[$];

    // 64-bit, 4-stage instance
    logic        v64 = 1'b0, fl64 = 1'b0, or64 = 1'b1, ir64, ov64, z64;
    logic [63:0] a64 = '0, b64 = '0, f64, exp64 = '0;
    logic [63:0] exp64_q[$];
    int          t64_q[$];

    logic [31:0] tbl32 [8];
    logic [7:0]  tbl8 [8];

    logic_unit_pipe #(.WIDTH(32), .STAGES(S32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a32), .b(b32), .out_valid(out_valid), .out_ready(out_ready), .f(f), .zero(zero)
    );
    logic_unit_pipe #(.WIDTH(8), .STAGES(S8)) dut8 (
        .clk(clk), .rst_n(rst_n), .flush(fl8), .in_valid(v8), .in_ready(ir8),
        .op(op), .a(a8), .b(b8), .out_valid(ov8), .out_ready(or8), .f(f8), .zero(z8)
    );
    logic_unit_pipe #(.WIDTH(64), .STAGES(S64)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(fl64), .in_valid(v64), .in_ready(ir64),
        .op(op), .a(a64), .b(b64), .out_valid(ov64), .out_ready(or64), .f(f64), .zero(z64)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    endtask

    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        case (o)
            3'd0: return x & y;
            3'd1: return x | y;
            3'd2: return x ^ y;
            3'd3: return ~(x | y);
            3'd4: return ~(x & y);
            3'd5: return ~(x ^ y);
            3'd6: return x & ~y;
            default: return x;
        endcase
    endfunction

    // Scoreboards: compare on output transfer, drop in-flight on flush/reset, push on input transfer.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete(); t_q.delete();
            exp8_q.delete(); t8_q.delete();
            exp64_q.delete(); t64_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                check("exp_avail32", 64'(exp_q.size() > 0), 64'd1);
                if (exp_q.size() > 0) begin
                    logic [31:0] e;
                    int tc;
                    e = exp_q.pop_front();
                    tc = t_q.pop_front();
                    check("f32", 64'(f), 64'(e));
                    check("zero32", 64'(zero), 64'(e == 32'd0));
                    if (lat_on) check("lat32", 64'(cyc - tc), 64'(S32));
                end
            end
            if (flush) begin
                exp_q.delete(); t_q.delete();
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(exp32); t_q.push_back(cyc);
            end

            if (ov8 && or8) begin
                check("exp_avail8", 64'(exp8_q.size() > 0), 64'd1);
                if (exp8_q.size() > 0) begin
                    logic [7:0] e;
                    int tc;
                    e = exp8_q.pop_front();
                    tc = t8_q.pop_front();
                    check("f8", 64'(f8), 64'(e));
                    check("zero8", 64'(z8), 64'(e == 8'd0));
                    check("lat8", 64'(cyc - tc), 64'(S8));
                end
            end
            if (v8 && ir8) begin
                exp8_q.push_back(exp8); t8_q.push_back(cyc);
            end

            if (ov64 && or64) begin
                check("exp_avail64", 64'(exp64_q.size() > 0), 64'd1);
                if (exp64_q.size() > 0) begin
                    logic [63:0] e;
                    int tc;
                    e = exp64_q.pop_front();
                    tc = t64_q.pop_front();
                    check("f64", f64, e);
                    check("zero64", 64'(z64), 64'(e == 64'd0));
                    check("lat64", 64'(cyc - tc), 64'(S64));
                end
            end
            if (v64 && ir64) begin
                exp64_q.push_back(exp64); t64_q.push_back(cyc);
            end
        end
    end

    always @(posedge clk) begin
        if (rnd_bp) begin
            #1 out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic send();
        int n = 0;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        check("send_accept", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input logic [31:0] e);
        op = o; a32 = x; b32 = y; exp32 = e;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (n < 60 && (exp_q.size() != 0 || exp8_q.size() != 0 || exp64_q.size() != 0)) begin
            n++;
            @(posedge clk);
            #2;
        end
        check("drain32", 64'(exp_q.size()), 64'd0);
        check("drain8", 64'(exp8_q.size()), 64'd0);
        check("drain64", 64'(exp64_q.size()), 64'd0);
    endtask

    initial begin
        int acc;
        int idx;
        int c;
        logic [31:0] f_hold;

        tbl32 = '{32'h0F0F0000, 32'hFFFF0F0F, 32'hF0F00F0F, 32'h0000F0F0,
                  32'hF0F0FFFF, 32'h0F0FF0F0, 32'hF0F00000, 32'hFFFF0000};
        tbl8  = '{8'h00, 8'hFF, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hF0, 8'hF0};

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_f", 64'(f), 64'd0);
        check("rst_zero", 64'(zero), 64'd0);
        check("rst_out_valid64", 64'(ov64), 64'd0);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);

        // Op sweep on all three builds, free-flowing output
        lat_on = 1'b1;
        out_ready = 1'b1;
        v8 = 1'b1;
        v64 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            set_op(3'(i), 32'hFFFF0000, 32'h0F0F0F0F, tbl32[i]);
            a8 = 8'hF0; b8 = 8'h0F; exp8 = tbl8[i];
            a64 = 64'hFFFF0000FFFF0000; b64 = 64'h0F0F0F0F0F0F0F0F; exp64 = {tbl32[i], tbl32[i]};
            send();
        end
        in_valid = 1'b0; v8 = 1'b0; v64 = 1'b0;
        wait_drain();

        // Zero flag
        set_op(3'd0, 32'hAAAAAAAA, 32'h55555555, 32'h00000000); send();
        set_op(3'd5, 32'hAAAAAAAA, 32'h55555555, 32'h00000000); send();
        set_op(3'd1, 32'hAAAAAAAA, 32'h55555555, 32'hFFFFFFFF); send();
        in_valid = 1'b0;
        wait_drain();

        // Random ops under random consumer stalls
        lat_on = 1'b0;
        rnd_bp = 1'b1;
        for (int i = 0; i < 24; i++) begin
            logic [2:0]  ro;
            logic [31:0] ra, rb;
            ro = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = (i % 4 == 0) ? ra : $urandom;
            set_op(ro, ra, rb, model(ro, ra, rb));
            send();
        end
        in_valid = 1'b0;
        rnd_bp = 1'b0;
        @(posedge clk);
        #1 out_ready = 1'b1;
        wait_drain();

        // Backpressure: 6 back-to-back ops against a stalled consumer
        out_ready = 1'b0;
        acc = 0;
        idx = 0;
        f_hold = '0;
        for (c = 0; c < 6; c++) begin
            set_op(3'(idx), 32'h12345678 + 32'(idx), 32'h0F0F00FF, model(3'(idx), 32'h12345678 + 32'(idx), 32'h0F0F00FF));
            in_valid = 1'b1;
            @(negedge clk);
            if (in_ready) begin
                acc++;
                idx++;
            end
            if (c == 3) f_hold = f;
            @(posedge clk);
            #1;
        end
        check("bp_accepts", 64'(acc), 64'(S32));
        check("bp_in_ready", 64'(in_ready), 64'd0);
        check("bp_out_valid", 64'(out_valid), 64'd1);
        check("bp_f_stable", 64'(f), 64'(f_hold));
        out_ready = 1'b1;
        #1;
        check("bp_pass_through", 64'(in_ready), 64'd1);
        c = 0;
        while (idx < 6 && c < 50) begin
            set_op(3'(idx), 32'h12345678 + 32'(idx), 32'h0F0F00FF, model(3'(idx), 32'h12345678 + 32'(idx), 32'h0F0F00FF));
            send();
            idx++;
            c++;
        end
        in_valid = 1'b0;
        check("bp_all_sent", 64'(idx), 64'd6);
        wait_drain();

        // Flush with two ops in flight and a concurrent input
        set_op(3'd2, 32'hDEADBEEF, 32'h0000FFFF, model(3'd2, 32'hDEADBEEF, 32'h0000FFFF)); send();
        set_op(3'd1, 32'h00F00000, 32'h00000F00, model(3'd1, 32'h00F00000, 32'h00000F00)); send();
        set_op(3'd7, 32'hCAFEF00D, 32'h0, 32'hCAFEF00D);
        flush = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        check("flush_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("flush_out_valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        lat_on = 1'b1;
        set_op(3'd6, 32'hFFFFFFFF, 32'h0000FFFF, 32'hFFFF0000); send();
        in_valid = 1'b0;
        wait_drain();

        // Asynchronous reset mid-stream
        lat_on = 1'b0;
        set_op(3'd1, 32'h11110000, 32'h00002222, 32'h11112222); send();
        set_op(3'd4, 32'h0, 32'h0, 32'hFFFFFFFF); send();
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_f", 64'(f), 64'd0);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        lat_on = 1'b1;
        set_op(3'd0, 32'h00000001, 32'h00000001, 32'h00000001); send();
        in_valid = 1'b0;
        wait_drain();

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/logic_unit_pipe.md
Name: logic_unit_pipe

Overview:
- Parametrised, pipelined bitwise logic unit: successor to the fixed 32-bit combinational AND32.
- Adds configurable width, eight selectable logic ops, a zero flag, and a configurable pipeline depth.
- Uses valid/ready handshakes on input and output, plus a synchronous flush.
- Sits in the EX stage as the logic-op lane alongside the adder; flush is driven by branch-mispredict recovery.

Parameters:
- WIDTH, 32, operand/result width in bits (>=1).
- STAGES, 2, number of register stages between input acceptance and output (1..4).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous clear of all in-flight operations
- in_valid  input  1  operands/op valid
- in_ready  output  1  unit can accept this cycle
- op  input  3  operation select
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- f  output  WIDTH  result
- zero  output  1  high when f == 0 (meaningful only with out_valid)

Behaviour:
- Reset (rst_n low, async): all stage valid bits 0, out_valid 0, f 0, zero 0. Stage data registers also clear to 0.
- Op encoding:
  - 000 AND, 001 OR, 010 XOR, 011 NOR
  - 100 NAND, 101 XNOR, 110 ANDN (a & ~b), 111 PASSA (a)
- Result is computed combinationally from a/b/op and captured into stage 0 with the zero flag.
  - Later stages only carry {f, zero}.
  - Outputs are driven from the final stage register; there is no combinational path from a/b to f.
- Handshake: a transfer occurs when valid & ready are both high at a rising edge. Input and output transfers are independent.
- Stage advance rule:
  - Stage k loads from stage k-1 (or from the input for k=0) when stage k is empty or stage k is advancing.
  - The final stage advances when out_ready is high.
  - in_ready = !flush & (stage0 empty | stage0 advancing). The ready chain is combinational back from out_ready; no bubbles are inserted.
- Latency: with out_ready held high, a result accepted at edge N has out_valid/f valid after edge N+STAGES-1, i.e. it is visible during cycle N+STAGES.
- Throughput: one op per cycle sustained.
- Backpressure: while out_valid=1 and out_ready=0, f and zero hold stable. Upstream stages fill, then in_ready drops. No data is lost or duplicated.
- Full pipeline (all STAGES valid, out_ready=0): in_ready=0. When out_ready rises, in_ready rises in the same cycle (pass-through).
- Empty pipeline: out_valid=0 and f/zero hold their last values. The consumer must ignore them.
- Flush (sampled at clock edge): all valid bits clear next cycle. in_ready=0 during the flush cycle.
  - Any simultaneous input is not accepted.
  - Any simultaneous output transfer (out_valid & out_ready) still counts as delivered.
  - Data registers are not cleared by flush.
- Reset mid-operation: all in-flight ops are discarded immediately (async). The first accepted input after release behaves as from an empty pipeline.
- Width: every op is purely bitwise over WIDTH bits with no carry. zero = ~|f.

Test Plan:
- Reset, then with out_ready=1 send a=0xFFFF0000, b=0x0F0F0F0F through all ops 000..111. Required results, in order, each appearing exactly STAGES cycles after acceptance:
  - 0x0F0F0000, 0xFFFF0F0F, 0xF0F00F0F, 0x0000F0F0
  - 0xF0F0FFFF, 0x0F0FF0F0, 0xF0F00000, 0xFFFF0000
- Zero flag: AND with a=0xAAAAAAAA, b=0x55555555 -> f=0x00000000, zero=1. XNOR with the same operands -> f=0x00000000, zero=1. OR with the same operands -> f=0xFFFFFFFF, zero=0.
- Backpressure: stream 6 back-to-back ops with out_ready=0 from cycle 2.
  - in_ready must drop after STAGES accepts.
  - f must stay stable.
  - On out_ready=1, all 6 results emerge in order with none lost or duplicated.
- Flush: with 2 ops in flight, assert flush for one cycle together with in_valid=1.
  - Next cycle out_valid=0; the flushed and concurrent inputs never appear.
  - The next op after flush emerges with normal latency.
- Async reset: drop rst_n mid-stream (not on a clock edge).
  - out_valid and f go to 0 immediately.
  - After release, the first op (a=1, b=1, AND) gives f=0x00000001, zero=0.
- Parameter sweep: repeat the first scenario with WIDTH=8, STAGES=1 (latency 1, f=0x00 for AND of 0xF0 & 0x0F) and with WIDTH=64, STAGES=4.
